// File: rtl/data_mem_arbiter.sv
// Arbitrates the single data_memory port between the CPU data interface and a DMA/loader master.
// CPU is stalled through cpu_clk_enable while its access waits; DMA progress is bounded by MAX_STREAK.
module data_mem_arbiter #(
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic [31:0] cpu_data_address,
  input  logic        cpu_data_write,
  input  logic        cpu_data_read,
  input  logic [31:0] cpu_data_writedata,
  output logic [31:0] cpu_data_readdata,
  output logic        cpu_clk_enable,
  input  logic        dma_valid,
  input  logic        dma_write,
  input  logic [31:0] dma_address,
  input  logic [31:0] dma_writedata,
  output logic        dma_ready,
  output logic [31:0] dma_rdata,
  output logic        dma_rvalid,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writedata,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_readdata
);

  localparam int unsigned SW = $clog2(MAX_STREAK + 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, CPU_DONE, DMA_DONE} state_t;
  typedef enum logic {OWN_CPU, OWN_DMA} owner_t;

  state_t        state_q, state_d;
  owner_t        owner_q, owner_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;

  logic cpu_req, streak_full, grant_ok, cpu_win, dma_win;

  // Grants are also gated by reset so every output is quiet while reset is held.
  assign cpu_req     = cpu_data_read | cpu_data_write;
  assign streak_full = (streak_q == SW'(MAX_STREAK));
  assign grant_ok    = reset & clk_enable & (state_q == IDLE);
  assign cpu_win     = grant_ok & cpu_req & ~(dma_valid & streak_full);
  assign dma_win     = grant_ok & ~cpu_win & dma_valid;

  assign cpu_data_readdata = rdata_q;
  assign dma_rdata         = rdata_q;
  assign dma_ready         = dma_win;

  always_comb begin
    // NOTE: every output and next-state value gets a default first, so no path can infer a latch.
    state_d        = state_q;
    owner_d        = owner_q;
    cnt_d          = cnt_q;
    rdata_d        = rdata_q;
    streak_d       = streak_q;
    mem_address    = '0;
    mem_writedata  = '0;
    mem_write      = 1'b0;
    mem_read       = 1'b0;
    dma_rvalid     = 1'b0;
    cpu_clk_enable = reset & clk_enable & ~cpu_req;

    if (!dma_valid || dma_win) begin
      streak_d = '0;
    end else if (cpu_win && !streak_full) begin
      streak_d = streak_q + SW'(1);
    end

    case (state_q)
      IDLE: begin
        if (cpu_win) begin
          mem_address   = cpu_data_address;
          mem_writedata = cpu_data_writedata;
          if (cpu_data_write) begin
            mem_write      = 1'b1;
            cpu_clk_enable = 1'b1;
          end else begin
            mem_read = 1'b1;
            owner_d  = OWN_CPU;
            cnt_d    = 3'd1;
            state_d  = RD_WAIT;
          end
        end else if (dma_win) begin
          mem_address   = dma_address;
          mem_writedata = dma_writedata;
          if (dma_write) begin
            mem_write = 1'b1;
          end else begin
            mem_read = 1'b1;
            owner_d  = OWN_DMA;
            cnt_d    = 3'd1;
            state_d  = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        // Capture runs regardless of clk_enable; only the completion handshake waits for it.
        if (owner_q == OWN_CPU) cpu_clk_enable = 1'b0;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'(RD_LAT)) begin
          rdata_d = mem_readdata;
          state_d = (owner_q == OWN_CPU) ? CPU_DONE : DMA_DONE;
        end
      end
      CPU_DONE: begin
        cpu_clk_enable = clk_enable;
        if (clk_enable) state_d = IDLE;
      end
      DMA_DONE: begin
        dma_rvalid = clk_enable;
        if (clk_enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      owner_q  <= OWN_CPU;
      streak_q <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: an RD_LAT=1 instance for most scenarios and an RD_LAT=3 instance
// for the long-latency read and the reset-abort case. A behavioural memory serves both.
module tb_data_mem_arbiter;

  localparam logic T = 1'b1;
  localparam logic F = 1'b0;

  logic        clk, rst_n, rst3_n, clk_enable;
  logic [31:0] cpu_data_address, cpu_data_writedata, dma_address, dma_writedata;
  logic        cpu_data_write, cpu_data_read, dma_valid, dma_write;

  logic [31:0] cpu_data_readdata, dma_rdata, mem_address, mem_writedata, mem_readdata;
  logic        cpu_clk_enable, dma_ready, dma_rvalid, mem_write, mem_read;
  logic [31:0] cpu_data_readdata3, dma_rdata3, mem_address3, mem_writedata3, mem_readdata3;
  logic        cpu_clk_enable3, dma_ready3, dma_rvalid3, mem_write3, mem_read3;

  int errors = 0;
  int checks = 0;
  logic [31:0] cpu_q[$];
  logic [31:0] dma_q[$];

  data_mem_arbiter #(.RD_LAT(1), .MAX_STREAK(4)) dut (
    .clk(clk), .reset(rst_n), .clk_enable(clk_enable),
    .cpu_data_address(cpu_data_address), .cpu_data_write(cpu_data_write),
    .cpu_data_read(cpu_data_read), .cpu_data_writedata(cpu_data_writedata),
    .cpu_data_readdata(cpu_data_readdata), .cpu_clk_enable(cpu_clk_enable),
    .dma_valid(dma_valid), .dma_write(dma_write), .dma_address(dma_address),
    .dma_writedata(dma_writedata), .dma_ready(dma_ready), .dma_rdata(dma_rdata),
    .dma_rvalid(dma_rvalid), .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_write(mem_write), .mem_read(mem_read), .mem_readdata(mem_readdata)
  );

  data_mem_arbiter #(.RD_LAT(3), .MAX_STREAK(4)) dut3 (
    .clk(clk), .reset(rst3_n), .clk_enable(clk_enable),
    .cpu_data_address(cpu_data_address), .cpu_data_write(cpu_data_write),
    .cpu_data_read(cpu_data_read), .cpu_data_writedata(cpu_data_writedata),
    .cpu_data_readdata(cpu_data_readdata3), .cpu_clk_enable(cpu_clk_enable3),
    .dma_valid(dma_valid), .dma_write(dma_write), .dma_address(dma_address),
    .dma_writedata(dma_writedata), .dma_ready(dma_ready3), .dma_rdata(dma_rdata3),
    .dma_rvalid(dma_rvalid3), .mem_address(mem_address3), .mem_writedata(mem_writedata3),
    .mem_write(mem_write3), .mem_read(mem_read3), .mem_readdata(mem_readdata3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory is written only by dut; dut3 is only ever used for reads.
  logic [31:0] mem [256];
  logic [32:0] p1;
  logic [2:0][32:0] p3;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
  end

  always @(posedge clk) begin
    if (mem_write) mem[mem_address[9:2]] <= mem_writedata;
    p1 <= {mem_read, mem_address};
    p3 <= {p3[1:0], {mem_read3, mem_address3}};
  end

  assign mem_readdata  = p1[32]    ? mem[p1[9:2]]    : 32'hBAD0_BAD0;
  assign mem_readdata3 = p3[2][32] ? mem[p3[2][9:2]] : 32'hBAD0_BAD0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard: responses are popped when the DUT presents them.
  always @(negedge clk) begin
    if (rst_n && dma_rvalid) begin
      if (dma_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dma_rvalid_unexpected: got pulse with data 0x%08h, expected none", dma_rdata);
      end else begin
        check("sb_dma_rdata", dma_rdata, dma_q.pop_front());
      end
    end
    if (rst_n && cpu_clk_enable && cpu_data_read && !cpu_data_write) begin
      if (cpu_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cpu_done_unexpected: got completion with 0x%08h, expected none", cpu_data_readdata);
      end else begin
        check("sb_cpu_readdata", cpu_data_readdata, cpu_q.pop_front());
      end
    end
  end

  typedef struct {
    logic        ce, crd, cwr;
    logic [31:0] caddr, cwd;
    logic        dv, dw;
    logic [31:0] daddr, dwd;
    logic        e_mw, e_mr, e_rdy, e_cce;
    logic [31:0] e_addr, e_wd;
  } vec_t;

  vec_t vecs[11];

  task automatic idle_inputs();
    clk_enable = 1'b1;
    cpu_data_read = 1'b0;  cpu_data_write = 1'b0;
    cpu_data_address = '0; cpu_data_writedata = '0;
    dma_valid = 1'b0;      dma_write = 1'b0;
    dma_address = '0;      dma_writedata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, c, acc_c, rv_c, done_c, stall, rd_pulses, npulse, rv_seen;

    // Single-cycle grant vectors in IDLE; streak grows across vectors 4..7 and forces the DMA at 8.
    vecs[0]  = '{T,F,F,32'h0,32'h0,        F,F,32'h0,32'h0,    F,F,F,T, 32'h0,32'h0};
    vecs[1]  = '{F,F,T,32'h14,32'h1,       F,F,32'h0,32'h0,    F,F,F,F, 32'h0,32'h0};
    vecs[2]  = '{T,F,T,32'h10,32'hDEADBEEF,F,F,32'h0,32'h0,    T,F,F,T, 32'h10,32'hDEADBEEF};
    vecs[3]  = '{T,F,F,32'h0,32'h0,        T,T,32'h20,32'h1234,T,F,T,T, 32'h20,32'h1234};
    vecs[4]  = '{T,F,T,32'h24,32'hA,       T,T,32'h28,32'hB,   T,F,F,T, 32'h24,32'hA};
    vecs[5]  = vecs[4];
    vecs[6]  = vecs[4];
    vecs[7]  = vecs[4];
    vecs[8]  = '{T,F,T,32'h24,32'hA,       T,T,32'h28,32'hB,   T,F,T,F, 32'h28,32'hB};
    vecs[9]  = '{T,T,T,32'h30,32'h55,      F,F,32'h0,32'h0,    T,F,F,T, 32'h30,32'h55};
    vecs[10] = '{F,F,F,32'h0,32'h0,        T,T,32'h2C,32'h3,   F,F,F,F, 32'h0,32'h0};

    // Reset state with busy inputs: everything must stay quiet.
    rst_n = 1'b0; rst3_n = 1'b0;
    idle_inputs();
    cpu_data_read = 1'b1; cpu_data_address = 32'h10;
    dma_valid = 1'b1; dma_address = 32'h40;
    @(negedge clk);
    check("rst_mem_write", 32'(mem_write), 32'h0);
    check("rst_mem_read", 32'(mem_read), 32'h0);
    check("rst_mem_address", mem_address, 32'h0);
    check("rst_mem_writedata", mem_writedata, 32'h0);
    check("rst_dma_ready", 32'(dma_ready), 32'h0);
    check("rst_dma_rvalid", 32'(dma_rvalid), 32'h0);
    check("rst_cpu_clk_enable", 32'(cpu_clk_enable), 32'h0);
    check("rst_cpu_readdata", cpu_data_readdata, 32'h0);
    check("rst_dma_rdata", dma_rdata, 32'h0);
    @(posedge clk); #1;
    idle_inputs();
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      clk_enable = vecs[i].ce;
      cpu_data_read = vecs[i].crd; cpu_data_write = vecs[i].cwr;
      cpu_data_address = vecs[i].caddr; cpu_data_writedata = vecs[i].cwd;
      dma_valid = vecs[i].dv; dma_write = vecs[i].dw;
      dma_address = vecs[i].daddr; dma_writedata = vecs[i].dwd;
      @(negedge clk);
      check($sformatf("v%0d_mem_write", i), 32'(mem_write), 32'(vecs[i].e_mw));
      check($sformatf("v%0d_mem_read", i), 32'(mem_read), 32'(vecs[i].e_mr));
      check($sformatf("v%0d_dma_ready", i), 32'(dma_ready), 32'(vecs[i].e_rdy));
      check($sformatf("v%0d_cpu_clk_enable", i), 32'(cpu_clk_enable), 32'(vecs[i].e_cce));
      check($sformatf("v%0d_mem_address", i), mem_address, vecs[i].e_addr);
      check($sformatf("v%0d_mem_writedata", i), mem_writedata, vecs[i].e_wd);
    end

    // CPU read of 0x10, RD_LAT=1: stall, stall, release with data.
    @(posedge clk); #1;
    idle_inputs();
    cpu_data_read = 1'b1; cpu_data_address = 32'h10;
    cpu_q.push_back(32'hDEADBEEF);
    rd_pulses = 0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      rd_pulses += int'(mem_read);
      check($sformatf("rd_cce_c%0d", j), 32'(cpu_clk_enable), 32'(j == 2));
      if (j == 0) check("rd_mem_address", mem_address, 32'h10);
      @(posedge clk); #1;
    end
    cpu_data_read = 1'b0;
    check("rd_mem_read_pulses", 32'(rd_pulses), 32'd1);

    // CPU write stream with a pending DMA read: four CPU grants, then the DMA.
    idle_inputs();
    dma_valid = 1'b1; dma_address = 32'h40;
    k = 0; c = 0; acc_c = -1; rv_c = -1; stall = 0;
    while (k < 8 && c < 40) begin
      cpu_data_write = 1'b1;
      cpu_data_address = 32'(k * 4);
      cpu_data_writedata = 32'hC0DE_0000 | 32'(k);
      @(negedge clk);
      if (cpu_clk_enable) k++; else stall++;
      if (dma_ready) begin
        acc_c = c;
        dma_q.push_back(32'hA500_0010);
      end
      if (dma_rvalid) rv_c = c;
      @(posedge clk); #1;
      if (acc_c >= 0) dma_valid = 1'b0;
      c++;
    end
    check("stream_dma_grant_cycle", 32'(acc_c), 32'd4);
    check("stream_dma_rvalid_cycle", 32'(rv_c), 32'd6);
    check("stream_cpu_stall_cycles", 32'(stall), 32'd3);
    check("stream_total_cycles", 32'(c), 32'd11);
    check("stream_mem_0x00", mem[0], 32'hC0DE_0000);
    check("stream_mem_0x1c", mem[7], 32'hC0DE_0007);

    // DMA write and CPU read together: CPU first, DMA right after CPU_DONE.
    idle_inputs();
    cpu_data_read = 1'b1; cpu_data_address = 32'h20;
    dma_valid = 1'b1; dma_write = 1'b1; dma_address = 32'h44; dma_writedata = 32'h77;
    cpu_q.push_back(32'h1234);
    done_c = -1; acc_c = -1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (cpu_clk_enable && cpu_data_read) done_c = j;
      if (dma_ready) begin
        acc_c = j;
        check("tie_dma_mem_address", mem_address, 32'h44);
      end
      @(posedge clk); #1;
      if (done_c >= 0) cpu_data_read = 1'b0;
      if (acc_c >= 0) dma_valid = 1'b0;
    end
    check("tie_cpu_done_cycle", 32'(done_c), 32'd2);
    check("tie_dma_accept_cycle", 32'(acc_c), 32'd3);
    check("tie_mem_0x44", mem[17], 32'h77);

    // clk_enable low during a CPU read: completion held until it returns.
    idle_inputs();
    cpu_data_read = 1'b1; cpu_data_address = 32'h24;
    cpu_q.push_back(32'hA);
    done_c = -1; npulse = 0; rd_pulses = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      rd_pulses += int'(mem_read);
      if (cpu_clk_enable && cpu_data_read) begin
        npulse++;
        done_c = j;
      end
      @(posedge clk); #1;
      if (j == 0) clk_enable = 1'b0;
      if (j == 3) clk_enable = 1'b1;
      if (done_c >= 0) cpu_data_read = 1'b0;
    end
    check("ce_hold_done_cycle", 32'(done_c), 32'd4);
    check("ce_hold_pulse_count", 32'(npulse), 32'd1);
    check("ce_hold_mem_reads", 32'(rd_pulses), 32'd1);

    // RD_LAT=3 instance: full DMA read, then a reset that aborts one mid-flight.
    idle_inputs();
    rst_n = 1'b0; rst3_n = 1'b1;
    @(posedge clk); #1;
    dma_valid = 1'b1; dma_address = 32'h40;
    acc_c = -1; rv_c = -1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (dma_ready3) acc_c = j;
      if (dma_rvalid3) begin
        rv_c = j;
        check("lat3_dma_rdata", dma_rdata3, 32'hA500_0010);
      end
      @(posedge clk); #1;
      if (acc_c >= 0) dma_valid = 1'b0;
    end
    check("lat3_accept_cycle", 32'(acc_c), 32'd0);
    check("lat3_rvalid_cycle", 32'(rv_c), 32'd4);

    dma_valid = 1'b1; dma_address = 32'h44;
    @(negedge clk);
    check("abort_issue_ready", 32'(dma_ready3), 32'h1);
    @(posedge clk); #1;
    dma_valid = 1'b0;
    @(posedge clk); #3;
    rst3_n = 1'b0;
    #1;
    check("abort_mem_read", 32'(mem_read3), 32'h0);
    check("abort_mem_write", 32'(mem_write3), 32'h0);
    check("abort_mem_address", mem_address3, 32'h0);
    check("abort_mem_writedata", mem_writedata3, 32'h0);
    check("abort_dma_ready", 32'(dma_ready3), 32'h0);
    check("abort_dma_rvalid", 32'(dma_rvalid3), 32'h0);
    check("abort_cpu_clk_enable", 32'(cpu_clk_enable3), 32'h0);
    check("abort_dma_rdata", dma_rdata3, 32'h0);
    check("abort_cpu_readdata", cpu_data_readdata3, 32'h0);
    @(posedge clk);
    @(posedge clk); #1;
    rst3_n = 1'b1;
    cpu_data_write = 1'b1; cpu_data_address = 32'h48; cpu_data_writedata = 32'h99;
    @(negedge clk);
    check("post_rst_mem_write", 32'(mem_write3), 32'h1);
    check("post_rst_mem_address", mem_address3, 32'h48);
    check("post_rst_cpu_clk_enable", 32'(cpu_clk_enable3), 32'h1);
    @(posedge clk); #1;
    idle_inputs();
    rv_seen = 0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      rv_seen += int'(dma_rvalid3);
    end
    check("abort_no_rvalid", 32'(rv_seen), 32'h0);

    check("sb_cpu_leftover", 32'(cpu_q.size()), 32'h0);
    check("sb_dma_leftover", 32'(dma_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Shares the single `data_memory` port between the `mips_cpu_harvard` data interface and a DMA/loader requester. The arbiter stalls the CPU through its `clk_enable` input while the CPU's access is pending or the port is busy. It sequences read latency for both requesters and guarantees DMA forward progress with a bounded CPU streak. It sits between the CPU, the DMA master and `data_memory`, replacing the direct CPU-to-memory wiring.

## Interface
- `RD_LAT`, default 1: memory read latency in cycles from the `mem_read` issue cycle to valid `mem_readdata`. Legal range 1..4.
- `MAX_STREAK`, default 4: maximum consecutive CPU grants while `dma_valid` is pending.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset).
- `clk_enable`  in  1  global enable. When low: no new grants and `cpu_clk_enable` = 0. In-flight reads still complete.
- `cpu_data_address`  in  32  CPU data address.
- `cpu_data_write`  in  1  CPU write request.
- `cpu_data_read`  in  1  CPU read request.
- `cpu_data_writedata`  in  32  CPU write data.
- `cpu_data_readdata`  out  32  captured read data; valid in CPU_DONE.
- `cpu_clk_enable`  out  1  drives the CPU `clk_enable`; low = CPU stalled.
- `dma_valid`  in  1  DMA request; held until accepted.
- `dma_write`  in  1  1 = write, 0 = read.
- `dma_address`  in  32  DMA address.
- `dma_writedata`  in  32  DMA write data.
- `dma_ready`  out  1  request accepted this cycle.
- `dma_rdata`  out  32  DMA read data.
- `dma_rvalid`  out  1  one-cycle pulse; `dma_rdata` valid.
- `mem_address`  out  32  address to `data_memory`.
- `mem_writedata`  out  32  write data to `data_memory`.
- `mem_write`  out  1  write strobe to `data_memory`.
- `mem_read`  out  1  read strobe to `data_memory`.
- `mem_readdata`  in  32  read data from `data_memory`.

## Operation
- States: IDLE, RD_WAIT, CPU_DONE, DMA_DONE. A register `owner` (CPU/DMA) records who issued the pending read.
- `cpu_req` = `cpu_data_read | cpu_data_write`.
- If both CPU strobes are high, the access is treated as a write and the read is ignored.
- Grant happens only in IDLE with `clk_enable` = 1:
  - CPU wins if `cpu_req` and not (`dma_valid` and `streak` == MAX_STREAK).
  - Otherwise DMA wins if `dma_valid`.
- `streak`:
  - Increments on each CPU grant while `dma_valid` = 1, saturating at MAX_STREAK.
  - Clears on a DMA grant or any cycle with `dma_valid` = 0.
- Issue cycle:
  - `mem_address`/`mem_writedata` mux combinationally from the winner; `mem_write` or `mem_read` = 1 for exactly that cycle.
  - With no issue, `mem_*` strobes are 0 and address/data are 0.
- CPU write: completes in the issue cycle; `cpu_clk_enable` = 1 that cycle; stay in IDLE.
- DMA write: `dma_ready` = 1 in the issue cycle; stay in IDLE.
- Reads (either requester):
  - Go to RD_WAIT, and the counter loads 1.
  - In RD_WAIT the counter increments. On the cycle the counter == RD_LAT, `mem_readdata` is registered into `rdata_q`.
  - Then go to CPU_DONE or DMA_DONE per `owner`.
- CPU_DONE: `cpu_clk_enable` = 1, `cpu_data_readdata` = `rdata_q`, no grant issued, next state IDLE. This prevents re-issuing the still-asserted read.
- DMA_DONE: `dma_rvalid` = 1, `dma_rdata` = `rdata_q`, no grant, next state IDLE. A DMA read also raises `dma_ready` in its issue cycle.
- `cpu_clk_enable`, any state: = `clk_enable` & !`cpu_req` (CPU runs freely), except:
  - = 1 in a CPU write grant cycle and in CPU_DONE.
  - = 0 in RD_WAIT when `owner` = CPU.
- `cpu_data_readdata` and `dma_rdata` both always output `rdata_q`.

## Timing
- Reset (async assert): state IDLE, `streak` = 0, counter = 0, `rdata_q` = 0, `owner` = CPU. All outputs are 0, including `cpu_clk_enable`.
- Reset mid-read aborts the read with no `dma_rvalid` pulse.
- Deassertion takes effect at the next rising edge.
- Write latency: 1 cycle for both requesters.
- CPU read: `cpu_clk_enable` is low for RD_LAT + 1 cycles (issue + RD_WAIT), then high for 1 cycle.
- DMA read: issue at cycle t, `dma_rvalid` at cycle t + RD_LAT + 1. Next grant possible at t + RD_LAT + 2.
- DMA handshake: request accepted when `dma_valid` & `dma_ready`. DMA inputs are don't-care after acceptance.
- `clk_enable` dropping during RD_WAIT: capture proceeds. CPU_DONE/DMA_DONE is held until `clk_enable` returns high, so the response is not lost.

## Test plan
- CPU write to 0x10 of 0xDEADBEEF, no DMA → `mem_write` = 1 for 1 cycle at 0x10, `cpu_clk_enable` = 1 throughout.
- CPU read of 0x10, RD_LAT = 1, memory returns 0xDEADBEEF → `cpu_clk_enable` is 0,0,1 and `cpu_data_readdata` = 0xDEADBEEF in the third cycle. Exactly one `mem_read` pulse.
- CPU write stream to 0x0..0x1C with `dma_valid` held (read of 0x40) → after 4 CPU grants the DMA is granted, then `dma_rvalid` after 2 more cycles; the CPU stalls during the DMA read.
- DMA write and CPU read in the same IDLE cycle, `streak` = 0 → CPU wins and the DMA is accepted the cycle after CPU_DONE.
- Async reset pulse during a DMA RD_WAIT with RD_LAT = 3 → all outputs are 0 immediately, with no `dma_rvalid`. After release, the first grant is on the first edge with requests.
- `clk_enable` = 0 during a CPU RD_WAIT → CPU_DONE is held until `clk_enable` = 1, then the CPU receives the correct data with a single `cpu_clk_enable` pulse.
